sipo_window_ctrl: RTL and testbench
===================================

// Module: sipo_window_ctrl
// PURPOSE
//  Sequencer for the per-line 8-bit x 5-tap SIPO window registers in the disparity path.
//  Takes the raw pixel stream (valid/ready), generates the shared shift enable for the
//  left/right SIPO windows, and tracks column/row position.
//  Flags when the 5-pixel window is fully populated, so the disparity core sees only complete windows.
// PARAMETERS
//  IMG_W  640  pixels per line (>= WIN)
//  IMG_H  480  lines per frame (>= 1)
//  WIN    5    window depth; must equal the SIPO tap count
// PORTS
//  clk          in   1               single clock; all state on rising edge
//  rst_n        in   1               asynchronous, active-low reset
//  i_valid      in   1               upstream pixel present this cycle
//  i_sof        in   1               qualifies the i_valid pixel as first pixel of a frame
//  o_ready      out  1               block accepts pixel this cycle
//  i_dn_ready   in   1               disparity core can take a window this cycle
//  o_shift_en   out  1               en to all SIPO instances (combinational)
//  o_win_valid  out  1               SIPO o_vector holds a complete window (registered)
//  o_win_col    out  $clog2(IMG_W)   column of newest pixel in the valid window
//  o_win_row    out  $clog2(IMG_H)   row of the valid window
//  o_eol        out  1               with o_win_valid: last window of the line
//  o_eof        out  1               with o_win_valid: last window of the frame
//  o_err        out  1               sticky: i_sof seen mid-frame
// BEHAVIOUR
//  - Reset: state IDLE; col, row, fill cnt = 0; o_win_valid, o_eol, o_eof, o_err = 0.
//  - Accept = i_valid & o_ready. o_shift_en = Accept & (state != IDLE | i_sof).
//  - o_ready = 1 in IDLE; = i_dn_ready in FILL/RUN.
//  - IDLE: non-sof pixels accepted and dropped, no shift.
//    Accept & i_sof: shift, col=1, row=0, -> FILL.
//  - FILL: each shift increments col. The shift of pixel index WIN-1 (col == WIN-1 before
//    the increment) -> RUN, and asserts o_win_valid next cycle.
//  - RUN: every shift asserts o_win_valid the next cycle, for exactly 1 cycle,
//    with o_win_col = pixel index of that shift and o_win_row = row.
//  - Latency: 1 cycle from the accepting edge to o_win_valid. The SIPO updates on the same edge.
//  - Line wrap: the shift of col == IMG_W-1 sets o_eol with its window, col <- 0, row+1.
//    Next state: FILL if row < IMG_H-1.
//  - Last line, last pixel: o_eol & o_eof with its window, then -> IDLE.
//    Frame needs exactly IMG_W*IMG_H accepted pixels.
//  - Windows never span lines: the first WIN-1 pixels of each line produce no o_win_valid.
//    Windows per line = IMG_W-WIN+1.
//  - i_sof with Accept in FILL/RUN: frame restart. Set o_err; shift this pixel.
//    col=1, row=0, -> FILL. Any in-flight o_win_valid still pulses normally.
//  - i_valid low: no shift, counters hold, o_win_valid low next cycle.
//  - i_dn_ready low: o_ready low, no shift, state/counters hold.
//  - o_err cleared only by rst_n.
//  - Async reset mid-line: all state cleared immediately. SIPO contents are don't-care
//    because FILL re-primes them.
//  - Counter widths: $clog2 of the respective dimension; IMG_W-1 and IMG_H-1 must be representable.
// STRUCTURE
//  - Package sipo_ctrl_pkg holds:
//    - typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN} win_state_t;
//    - localparam WIN_DEF = 5.
//  - One sub-module, pix_coord_cnt:
//    - column/row counter with en, clear and load-1 inputs;
//    - outputs col, row, last_col, last_row.
//  - FSM and output registers stay in this module.
// TESTING (IMG_W=8, IMG_H=2, WIN=5)
//  1. Reset, then 16 back-to-back pixels (first with i_sof), i_dn_ready=1:
//     - o_win_valid pulses at cols 4..7 of row 0, then cols 4..7 of row 1;
//     - o_eol at col 7 (both rows); o_eof only with row 1 col 7;
//     - state IDLE after the last pixel.
//  2. Three pixels without i_sof in IDLE:
//     - o_ready=1, o_shift_en=0 throughout, no o_win_valid.
//  3. i_valid toggled 1/0 every cycle for a frame:
//     - 8 windows total, each exactly 1 cycle after its accepting edge, coordinates as in test 1.
//  4. i_dn_ready held 0 for 4 cycles in RUN at col 5:
//     - o_ready=0, o_shift_en=0, col stays 5;
//     - the next window after release has col 6.
//  5. i_sof asserted at row 0 col 6:
//     - o_err=1 and stays set;
//     - the next window is col 4 row 0 of the new frame.
//  6. rst_n pulsed low at row 1 col 3:
//     - all outputs 0 immediately;
//     - a fresh frame then produces the same sequence as test 1.

Source files
------------

// File: rtl/sipo_ctrl_pkg.sv
// Shared types and helpers for the SIPO window sequencer.
// The state encoding is common to the top module and any checker that observes it.
package sipo_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } win_state_t;

  localparam int WIN_DEF = 5;

  // Counter width for a dimension, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pix_coord_cnt.sv
// Column/row position counter for the pixel stream.
// Clear has priority over load-1, which has priority over a normal advance.
module pix_coord_cnt
  import sipo_ctrl_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       clr,
  input  logic                       load1,
  output logic [cnt_w(IMG_W)-1:0]    col,
  output logic [cnt_w(IMG_H)-1:0]    row,
  output logic                       last_col,
  output logic                       last_row
);

  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;

  // Position update: a load-1 marks the first pixel of a frame as already counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r <= '0;
      row_r <= '0;
    end else if (clr) begin
      col_r <= '0;
      row_r <= '0;
    end else if (load1) begin
      col_r <= CW'(1);
      row_r <= '0;
    end else if (en) begin
      if (last_col) begin
        col_r <= '0;
        row_r <= row_r + RW'(1);
      end else begin
        col_r <= col_r + CW'(1);
        row_r <= row_r;
      end
    end else begin
      col_r <= col_r;
      row_r <= row_r;
    end
  end

  assign col      = col_r;
  assign row      = row_r;
  assign last_col = (col_r == LAST_COL);
  assign last_row = (row_r == LAST_ROW);

endmodule

// File: rtl/sipo_window_ctrl.sv
// Sequencer for the left/right 5-tap SIPO windows: drives the shared shift enable,
// tracks pixel position and flags complete windows one cycle after their accepting edge.
module sipo_window_ctrl
  import sipo_ctrl_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int WIN   = WIN_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_valid,
  input  logic                       i_sof,
  output logic                       o_ready,
  input  logic                       i_dn_ready,
  output logic                       o_shift_en,
  output logic                       o_win_valid,
  output logic [cnt_w(IMG_W)-1:0]    o_win_col,
  output logic [cnt_w(IMG_H)-1:0]    o_win_row,
  output logic                       o_eol,
  output logic                       o_eof,
  output logic                       o_err
);

  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);
  localparam logic [CW-1:0] FIRST_WIN_COL = CW'(WIN - 1);

  win_state_t    state_r;
  win_state_t    next_state_s;
  logic [CW-1:0] col_s;
  logic [RW-1:0] row_s;
  logic          last_col_s;
  logic          last_row_s;
  logic          accept_s;
  logic          shift_s;
  logic          restart_s;
  logic          advance_s;
  logic          fire_s;
  logic          frame_end_s;

  logic          win_valid_r;
  logic [CW-1:0] win_col_r;
  logic [RW-1:0] win_row_r;
  logic          eol_r;
  logic          eof_r;
  logic          err_r;

  assign o_ready    = (state_r == S_IDLE) ? 1'b1 : i_dn_ready;
  assign accept_s   = i_valid & o_ready;
  assign o_shift_en = accept_s & ((state_r != S_IDLE) | i_sof);
  assign shift_s    = o_shift_en;
  // An sof shift always starts a frame, whether from IDLE or as a restart.
  assign restart_s   = shift_s & i_sof;
  assign advance_s   = shift_s & ~i_sof;
  assign frame_end_s = advance_s & last_col_s & last_row_s;
  assign fire_s      = advance_s & ((state_r == S_RUN) |
                                    ((state_r == S_FILL) & (col_s == FIRST_WIN_COL)));

  pix_coord_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_coord (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (advance_s),
    .clr      (frame_end_s),
    .load1    (restart_s),
    .col      (col_s),
    .row      (row_s),
    .last_col (last_col_s),
    .last_row (last_row_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; line wrap wins over the FILL->RUN transition when IMG_W == WIN.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (shift_s) begin
          next_state_s = S_FILL;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_FILL, S_RUN: begin
        if (restart_s) begin
          next_state_s = S_FILL;
        end else if (advance_s & last_col_s) begin
          next_state_s = last_row_s ? S_IDLE : S_FILL;
        end else if (advance_s & (state_r == S_FILL) & (col_s == FIRST_WIN_COL)) begin
          next_state_s = S_RUN;
        end else begin
          next_state_s = state_r;
        end
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  // Window flags and coordinates; coordinates hold between windows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid_r <= 1'b0;
      win_col_r   <= '0;
      win_row_r   <= '0;
      eol_r       <= 1'b0;
      eof_r       <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      win_valid_r <= fire_s;
      eol_r       <= fire_s & last_col_s;
      eof_r       <= fire_s & last_col_s & last_row_s;
      err_r       <= err_r | (restart_s & (state_r != S_IDLE));
      if (fire_s) begin
        win_col_r <= col_s;
        win_row_r <= row_s;
      end else begin
        win_col_r <= win_col_r;
        win_row_r <= win_row_r;
      end
    end
  end

  assign o_win_valid = win_valid_r;
  assign o_win_col   = win_col_r;
  assign o_win_row   = win_row_r;
  assign o_eol       = eol_r;
  assign o_eof       = eof_r;
  assign o_err       = err_r;

endmodule

// File: tb/tb_sipo_window_ctrl.sv
// Directed bench for sipo_window_ctrl with an 8x2 frame and a 5-tap window.
module tb_sipo_window_ctrl;

  localparam int IMG_W = 8;
  localparam int IMG_H = 2;
  localparam int WIN   = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_valid = 1'b0;
  logic       i_sof = 1'b0;
  logic       i_dn_ready = 1'b0;
  logic       o_ready;
  logic       o_shift_en;
  logic       o_win_valid;
  logic [2:0] o_win_col;
  logic [0:0] o_win_row;
  logic       o_eol;
  logic       o_eof;
  logic       o_err;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   win_cnt = 0;
  logic obs_shift;
  logic obs_ready;

  always #5 clk = ~clk;

  sipo_window_ctrl #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .WIN   (WIN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_valid     (i_valid),
    .i_sof       (i_sof),
    .o_ready     (o_ready),
    .i_dn_ready  (i_dn_ready),
    .o_shift_en  (o_shift_en),
    .o_win_valid (o_win_valid),
    .o_win_col   (o_win_col),
    .o_win_row   (o_win_row),
    .o_eol       (o_eol),
    .o_eof       (o_eof),
    .o_err       (o_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Starts at a falling edge, samples combinational outputs, returns at the next falling edge.
  task automatic cyc(input logic v, input logic s, input logic d);
    i_valid    = v;
    i_sof      = s;
    i_dn_ready = d;
    #1;
    obs_shift = o_shift_en;
    obs_ready = o_ready;
    @(negedge clk);
  endtask

  // Expected window after pixel p of a frame (p = row*8 + col).
  task automatic chk_win(input int p);
    int col;
    int row;
    col = p % IMG_W;
    row = p / IMG_W;
    chk("win_valid", 32'(o_win_valid), (col >= 4) ? 1 : 0);
    if (col >= 4) begin
      win_cnt++;
      chk("win_col", 32'(o_win_col), col);
      chk("win_row", 32'(o_win_row), row);
      chk("eol", 32'(o_eol), (col == 7) ? 1 : 0);
      chk("eof", 32'(o_eof), (col == 7 && row == 1) ? 1 : 0);
    end
  endtask

  task automatic run_frame(input bit gap);
    win_cnt = 0;
    for (int p = 0; p < 16; p++) begin
      cyc(1'b1, (p == 0), 1'b1);
      chk("shift_en", 32'(obs_shift), 1);
      chk_win(p);
      if (gap) begin
        cyc(1'b0, 1'b0, 1'b1);
        chk("gap_shift", 32'(obs_shift), 0);
        chk("gap_win_valid", 32'(o_win_valid), 0);
      end
    end
    chk("win_count", win_cnt, 8);
    cyc(1'b1, 1'b0, 1'b0);
    chk("idle_ready", 32'(obs_ready), 1);
    chk("idle_shift", 32'(obs_shift), 0);
  endtask

  initial begin
    i_dn_ready = 1'b1;
    #2;
    chk("rst_win_valid", 32'(o_win_valid), 0);
    chk("rst_eol", 32'(o_eol), 0);
    chk("rst_eof", 32'(o_eof), 0);
    chk("rst_err", 32'(o_err), 0);
    chk("rst_col", 32'(o_win_col), 0);
    chk("rst_row", 32'(o_win_row), 0);
    chk("rst_ready", 32'(o_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: back-to-back frame
    run_frame(1'b0);

    // 2: non-sof pixels in IDLE are dropped
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, (k != 1));
      chk("t2_ready", 32'(obs_ready), 1);
      chk("t2_shift", 32'(obs_shift), 0);
      chk("t2_win_valid", 32'(o_win_valid), 0);
    end

    // 3: valid toggling every cycle
    run_frame(1'b1);

    // 4: downstream stall after the col 5 window
    for (int p = 0; p < 6; p++) begin
      cyc(1'b1, (p == 0), 1'b1);
      chk_win(p);
    end
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b0, 1'b0);
      chk("t4_ready", 32'(obs_ready), 0);
      chk("t4_shift", 32'(obs_shift), 0);
      chk("t4_win_valid", 32'(o_win_valid), 0);
      chk("t4_win_col", 32'(o_win_col), 5);
    end
    for (int p = 6; p < 16; p++) begin
      cyc(1'b1, 1'b0, 1'b1);
      chk("t4_shift_rel", 32'(obs_shift), 1);
      chk_win(p);
    end
    cyc(1'b1, 1'b0, 1'b0);
    chk("t4_idle_ready", 32'(obs_ready), 1);
    chk("t4_err", 32'(o_err), 0);

    // 5: sof arrives at row 0 col 6
    for (int p = 0; p < 6; p++) begin
      cyc(1'b1, (p == 0), 1'b1);
      chk_win(p);
    end
    cyc(1'b1, 1'b1, 1'b1);
    chk("t5_shift", 32'(obs_shift), 1);
    chk("t5_err", 32'(o_err), 1);
    chk("t5_win_valid", 32'(o_win_valid), 0);
    for (int p = 1; p < 11; p++) begin
      cyc(1'b1, 1'b0, 1'b1);
      chk_win(p);
    end
    chk("t5_err_sticky", 32'(o_err), 1);

    // 6: async reset at row 1 col 3
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_win_valid", 32'(o_win_valid), 0);
    chk("t6_win_col", 32'(o_win_col), 0);
    chk("t6_win_row", 32'(o_win_row), 0);
    chk("t6_eol", 32'(o_eol), 0);
    chk("t6_eof", 32'(o_eof), 0);
    chk("t6_err", 32'(o_err), 0);
    chk("t6_shift", 32'(o_shift_en), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(1'b0);
    chk("t6_err_after", 32'(o_err), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
